// File: rtl/mux_ser_pkg.sv
// rtl/mux_ser_pkg.sv - shared state encoding for the mux serializer
package mux_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - WIDTH:1 bit select, out-of-range indices yield 0
module mux_nto1 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    // Compare-per-bit form keeps non-power-of-two widths free of unreachable index slots.
    always_comb begin
        y = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel == SEL_W'(i)) begin
                y = data[i];
            end
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - parallel word to serial bit stream via an indexed mux
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int SEL_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [SEL_W-1:0] sel,
    output logic             done
);

    localparam logic [SEL_W-1:0] FIRST_IDX = LSB_FIRST ? SEL_W'(0) : SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = LSB_FIRST ? SEL_W'(WIDTH - 1) : SEL_W'(0);

    ser_state_t       state, state_next;
    logic [WIDTH-1:0] held, held_next;
    logic [SEL_W-1:0] sel_next;
    logic             done_next;
    logic             mux_bit;

    mux_nto1 #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .data (held),
        .sel  (sel),
        .y    (mux_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            held  <= '0;
            sel   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            held  <= held_next;
            sel   <= sel_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        held_next  = held;
        sel_next   = sel;
        done_next  = 1'b0;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    held_next  = load_data;
                    sel_next   = FIRST_IDX;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                // Final index exits before stepping, so sel never wraps past the word.
                if (en) begin
                    if (sel == LAST_IDX) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (LSB_FIRST) begin
                        sel_next = sel + SEL_W'(1);
                    end else begin
                        sel_next = sel - SEL_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        ser_out = ser_valid & mux_bit;
    end

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - directed bench with a bit-count reference model
module tb_mux_serializer;
    import mux_ser_pkg::*;

    localparam int N = 3;
    localparam int W [N] = '{16, 16, 5};
    localparam bit L [N] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lv  [N];
    logic [15:0] ld  [N];
    logic        en  [N];
    logic        rdy [N];
    logic        so  [N];
    logic        sv  [N];
    logic        dn  [N];
    logic [3:0]  sel16l, sel16m;
    logic [2:0]  sel5;

    int vectors = 0;
    int miss    = 0;
    bit chk_en  = 1'b0;

    bit          m_busy   [N];
    logic [15:0] m_word   [N];
    int          m_k      [N];
    bit          m_done   [N];
    bit          m_selchk [N];
    logic        last_so  [N];
    logic        last_sv  [N];
    logic        last_rdy [N];
    logic [15:0] cap      [N];
    int          ncap     [N];

    always #5 clk = ~clk;

    mux_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) u16l (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .load_data(ld[0]),
        .en(en[0]), .ser_out(so[0]), .ser_valid(sv[0]), .sel(sel16l), .done(dn[0]));
    mux_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u16m (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .load_data(ld[1]),
        .en(en[1]), .ser_out(so[1]), .ser_valid(sv[1]), .sel(sel16m), .done(dn[1]));
    mux_serializer #(.WIDTH(5), .LSB_FIRST(1'b1)) u5 (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(rdy[2]), .load_data(ld[2][4:0]),
        .en(en[2]), .ser_out(so[2]), .ser_valid(sv[2]), .sel(sel5), .done(dn[2]));

    function automatic int get_sel(int i);
        if (i == 0) return int'(sel16l);
        if (i == 1) return int'(sel16m);
        return int'(sel5);
    endfunction

    task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(int i, bit toggle);
        int n = 0;
        while (dn[i] !== 1'b1 && n < 100) begin
            if (toggle) en[i] = ~en[i];
            step(1);
            n++;
        end
        vectors++;
        if (dn[i] !== 1'b1) begin
            miss++;
            $display("FAIL done_timeout[%0d]: got no done within %0d cycles expected done", i, n);
        end
    endtask

    // Model: a word is "busy" for exactly W en-qualified cycles; the bit index follows from the count.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (last_sv[i] === 1'b1 && en[i]) begin
                if (ncap[i] < W[i]) cap[i][L[i] ? ncap[i] : W[i] - 1 - ncap[i]] = last_so[i];
                ncap[i]++;
            end
            if (last_rdy[i] === 1'b1 && lv[i] && !rst) begin
                cap[i]  = '0;
                ncap[i] = 0;
            end
            if (rst) begin
                m_busy[i]   = 1'b0;
                m_k[i]      = 0;
                m_done[i]   = 1'b0;
                m_selchk[i] = 1'b1;
            end else begin
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (lv[i]) begin
                        m_busy[i] = 1'b1;
                        m_word[i] = ld[i] & 16'((32'h1 << W[i]) - 1);
                        m_k[i]    = 0;
                    end
                end else if (en[i]) begin
                    m_k[i]++;
                    if (m_k[i] == W[i]) begin
                        m_busy[i]   = 1'b0;
                        m_done[i]   = 1'b1;
                        m_selchk[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int idx;
            if (chk_en) begin
                idx = m_busy[i] ? (L[i] ? m_k[i] : W[i] - 1 - m_k[i]) : 0;
                chk("load_ready", i, rdy[i], !m_busy[i]);
                chk("ser_valid", i, sv[i], m_busy[i]);
                chk("done", i, dn[i], m_done[i]);
                chk("ser_out", i, so[i], m_busy[i] ? m_word[i][idx] : 1'b0);
                if (m_busy[i] || m_selchk[i]) chk("sel", i, get_sel(i), idx);
            end
            last_so[i]  = so[i];
            last_sv[i]  = sv[i];
            last_rdy[i] = rdy[i];
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            lv[i] = 1'b0; ld[i] = '0; en[i] = 1'b0;
            m_busy[i] = 1'b0; m_word[i] = '0; m_k[i] = 0; m_done[i] = 1'b0; m_selchk[i] = 1'b0;
            last_so[i] = 1'b0; last_sv[i] = 1'b0; last_rdy[i] = 1'b0; cap[i] = '0; ncap[i] = 0;
        end
        rst = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);

        // LSB-first AAAA with a load attempt mid-shift, MSB-first 8001, and a 5-bit word.
        for (int i = 0; i < N; i++) begin lv[i] = 1'b1; en[i] = 1'b1; end
        ld[0] = 16'hAAAA; ld[1] = 16'h8001; ld[2] = 16'h0016;
        step(1);
        for (int i = 0; i < N; i++) lv[i] = 1'b0;
        step(3);
        lv[0] = 1'b1; ld[0] = 16'h1234;
        step(2);
        lv[0] = 1'b0;
        wait_done(2, 1'b0);
        chk("cap_10110", 2, cap[2][4:0], 5'b10110);
        chk("en_count", 2, ncap[2], 5);
        lv[2] = 1'b1; ld[2] = 16'h0009;
        step(1);
        lv[2] = 1'b0;
        wait_done(2, 1'b0);
        chk("cap_01001", 2, cap[2][4:0], 5'b01001);
        wait_done(0, 1'b0);
        chk("cap_aaaa", 0, cap[0], 16'hAAAA);
        chk("en_count", 0, ncap[0], 16);
        wait_done(1, 1'b0);
        chk("cap_8001", 1, cap[1], 16'h8001);
        chk("en_count", 1, ncap[1], 16);
        step(2);

        // en alternating 1,0,1,0 during F0F0.
        lv[0] = 1'b1; ld[0] = 16'hF0F0; en[0] = 1'b1;
        step(1);
        lv[0] = 1'b0;
        wait_done(0, 1'b1);
        chk("cap_f0f0", 0, cap[0], 16'hF0F0);
        chk("en_count", 0, ncap[0], 16);
        step(2);

        // Reset at sel=7 overriding a simultaneous load, then a fresh word.
        en[0] = 1'b1; lv[0] = 1'b1; ld[0] = 16'h00FF;
        step(1);
        lv[0] = 1'b0;
        step(7);
        chk("sel_before_rst", 0, sel16l, 4'd7);
        rst = 1'b1; lv[0] = 1'b1; ld[0] = 16'h1234;
        step(1);
        rst = 1'b0; lv[0] = 1'b0;
        chk("rst_ser_valid", 0, sv[0], 1'b0);
        chk("rst_sel", 0, sel16l, 4'd0);
        chk("rst_done", 0, dn[0], 1'b0);
        step(2);
        lv[0] = 1'b1; ld[0] = 16'h00FF;
        step(1);
        lv[0] = 1'b0;
        wait_done(0, 1'b0);
        chk("cap_00ff", 0, cap[0], 16'h00FF);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/mux_serializer.md
MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the parallel word width in bits (legal range 2..64).
REQ-002 Parameter LSB_FIRST, default 1, SHALL select bit order: 1 = bit 0 first, 0 = bit WIDTH-1 first.
REQ-003 Localparam SEL_W SHALL equal $clog2(WIDTH).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 load_valid  input  1  load_data is offered this cycle.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 load_data  input  WIDTH  parallel word to serialise.
REQ-009 en  input  1  advance to the next bit this cycle.
REQ-010 ser_out  output  1  currently selected bit of the held word.
REQ-011 ser_valid  output  1  ser_out carries a valid bit.
REQ-012 sel  output  SEL_W  index of the bit currently on ser_out.
REQ-013 done  output  1  one-cycle pulse after the last bit is consumed.

Function
REQ-014 The FSM SHALL have states IDLE and SHIFT.
REQ-015 In IDLE: load_ready=1, ser_valid=0, ser_out=0.
REQ-016 In IDLE, load_valid=1 SHALL capture load_data into a WIDTH-bit holding register, load sel with 0 (LSB_FIRST=1) or WIDTH-1 (LSB_FIRST=0), and enter SHIFT next cycle.
REQ-017 Latency: the first bit SHALL appear on ser_out with ser_valid=1 exactly one cycle after the accepting edge.
REQ-018 In SHIFT: load_ready=0, ser_valid=1, ser_out = held[sel] (combinational WIDTH:1 select of the registered word).
REQ-019 In SHIFT, en=1 on a non-final index SHALL step sel by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0); en=0 SHALL hold sel and ser_out unchanged.
REQ-020 In SHIFT, en=1 on the final index (WIDTH-1 for LSB_FIRST=1, 0 otherwise) SHALL return to IDLE and assert done for exactly the next cycle.
REQ-021 sel SHALL never leave 0..WIDTH-1, including for non-power-of-two WIDTH.
REQ-022 load_valid in SHIFT SHALL be ignored; the held word SHALL not change.
REQ-023 The cycle done=1 is in IDLE with load_ready=1; a load there SHALL be accepted (back-to-back words, one idle cycle between).
REQ-024 Exactly WIDTH en-qualified cycles SHALL occur between acceptance and done.

Reset
REQ-025 rst=1 SHALL force IDLE, sel=0, holding register=0, done=0, ser_valid=0, ser_out=0 at the next edge.
REQ-026 rst during SHIFT SHALL discard the word with no done pulse; rst SHALL override a simultaneous load_valid.

Structure
REQ-027 State encoding (IDLE/SHIFT) SHALL live in a shared package, mux_ser_pkg, used by RTL and bench.
REQ-028 The WIDTH:1 bit select SHALL be one sub-module, mux_nto1 (parameter WIDTH), instantiated once.
REQ-029 Total RTL SHALL fit 120-400 lines.

Verification
REQ-030 WIDTH=16, LSB_FIRST=1, load 16'hAAAA, en=1 held -> ser_out 0,1,0,1,... for 16 cycles, sel 0..15, done one cycle after sel=15.
REQ-031 WIDTH=16, LSB_FIRST=0, load 16'h8001 -> ser_out 1, fourteen 0s, 1; sel 15..0; done after 16 en cycles.
REQ-032 en toggled 1,0,1,0 during 16'hF0F0 -> sel advances only on en=1 cycles; done after 16 en-high cycles.
REQ-033 load_valid=1 with 16'h1234 during SHIFT of 16'hAAAA -> ignored, AAAA pattern completes unchanged.
REQ-034 rst=1 at sel=7 -> next cycle IDLE, sel=0, ser_valid=0, no done; new load 16'h00FF then serialises correctly.
REQ-035 WIDTH=5, LSB_FIRST=1, load 5'b10110 -> ser_out 0,1,1,0,1; sel never exceeds 4; back-to-back load in done cycle accepted.
